onehot_serializer: RTL and testbench

Inverse of the parameterised one-hot decoder (C-bit index to O = 1<<C wide vector). Accepts an O-bit bitmap over a valid/ready handshake and emits the C-bit index of every set bit, one per beat, lowest index first, over a second valid/ready handshake. It sits downstream of decoded request/grant vectors and turns them back into an index stream for encoded consumers.

---
 rtl/onehot_serializer.sv | 145 ++++++++++++++
 tb/tb_onehot_serializer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/onehot_serializer.sv
// Bitmap-to-index serializer: emits the index of every set bit of an accepted bitmap, lowest first.
// Optional ONEHOT_SER_EMPTY_FLAG_EN: an all-zero bitmap yields one beat flagged on out_empty.
module onehot_serializer #(
    parameter  int C = 3,
    localparam int O = 1 << C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [O-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [C-1:0] out_idx,
    output logic         out_last
`ifdef ONEHOT_SER_EMPTY_FLAG_EN
    ,
    output logic         out_empty
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

`ifdef ONEHOT_SER_EMPTY_FLAG_EN
    localparam logic EMPTY_EN_C = 1'b1;
`else
    localparam logic EMPTY_EN_C = 1'b0;
`endif

    localparam logic [O-1:0] ONE_C  = {{(O-1){1'b0}}, 1'b1};
    localparam logic [O-1:0] ZERO_C = {O{1'b0}};

    state_t         state_r;
    state_t         state_nxt_s;
    logic [O-1:0]   pend_r;
    logic [O-1:0]   pend_nxt_s;
    logic           empty_r;
    logic           empty_nxt_s;
    logic [C-1:0]   low_idx_s;
    logic           single_s;
    logic           last_s;
    logic           accept_s;
    logic           fire_s;

    function automatic logic [C-1:0] lowest_idx(input logic [O-1:0] v);
        logic [C-1:0] idx;
        idx = {C{1'b0}};
        for (int k = O - 1; k >= 0; k--) begin
            if (v[k]) begin
                idx = k[C-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Decode the head beat from the pending register only.
    always_comb begin
        low_idx_s = lowest_idx(pend_r);
        single_s  = (pend_r != ZERO_C) && ((pend_r & (pend_r - ONE_C)) == ZERO_C);
        last_s    = single_s || (EMPTY_EN_C && empty_r);
    end

    // State, pending bitmap and empty flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pend_r  <= ZERO_C;
            empty_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            empty_r <= EMPTY_EN_C && empty_nxt_s;
        end
    end

    // Next-state: retire the head beat, then overlay a new bitmap when one is accepted.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        empty_nxt_s = empty_r;
        accept_s    = in_valid && in_ready;
        fire_s      = out_valid && out_ready;
        if (fire_s) begin
            pend_nxt_s  = pend_r & (pend_r - ONE_C);
            empty_nxt_s = 1'b0;
            if (last_s) begin
                state_nxt_s = IDLE;
            end else begin
                state_nxt_s = BUSY;
            end
        end else begin
            state_nxt_s = state_r;
        end
        if (accept_s) begin
            pend_nxt_s  = in_vec;
            empty_nxt_s = (in_vec == ZERO_C);
            // Without the flag a zero bitmap is swallowed and leaves the state as it was.
            if ((in_vec != ZERO_C) || EMPTY_EN_C) begin
                state_nxt_s = BUSY;
            end else begin
                state_nxt_s = state_nxt_s;
            end
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // Outputs: handshake and beat fields, all forced low while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = {C{1'b0}};
        out_last  = 1'b0;
`ifdef ONEHOT_SER_EMPTY_FLAG_EN
        out_empty = 1'b0;
`endif
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready  = 1'b1;
                    out_valid = 1'b0;
                end
                BUSY: begin
                    in_ready  = out_ready && last_s;
                    out_valid = 1'b1;
                    out_idx   = (EMPTY_EN_C && empty_r) ? {C{1'b0}} : low_idx_s;
                    out_last  = last_s;
`ifdef ONEHOT_SER_EMPTY_FLAG_EN
                    out_empty = empty_r;
`endif
                end
                default: begin
                    in_ready  = 1'b0;
                    out_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_serializer.sv
// Bench for onehot_serializer (C=2): directed scenarios then random traffic against a beat-queue model.
module tb_onehot_serializer;

    localparam int C = 2;
    localparam int O = 4;

    typedef struct packed {
        logic [C-1:0] idx;
        logic         empty;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [O-1:0] in_vec = 4'b0000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [C-1:0] out_idx;
    logic         out_last;
`ifdef ONEHOT_SER_EMPTY_FLAG_EN
    logic         out_empty;
`endif

    int checks = 0;
    int errors = 0;
    beat_t q[$];

    onehot_serializer #(.C(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef ONEHOT_SER_EMPTY_FLAG_EN
        ,
        .out_empty (out_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, update the model at the edge.
    task automatic cyc(input logic r, input logic iv, input logic [O-1:0] vec, input logic ordy);
        logic  exp_rdy;
        logic  exp_vld;
        beat_t b;
        rst = r; in_valid = iv; in_vec = vec; out_ready = ordy;
        @(negedge clk);
        exp_vld = !r && (q.size() > 0);
        exp_rdy = !r && ((q.size() == 0) || (ordy && q.size() == 1));
        chk("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
        chk("out_valid", {7'd0, out_valid}, {7'd0, exp_vld});
        if (exp_vld) begin
            chk("out_idx", {6'd0, out_idx}, {6'd0, q[0].idx});
            chk("out_last", {7'd0, out_last}, {7'd0, (q.size() == 1)});
`ifdef ONEHOT_SER_EMPTY_FLAG_EN
            chk("out_empty", {7'd0, out_empty}, {7'd0, q[0].empty});
`endif
        end else begin
            chk("out_idx_idle", {6'd0, out_idx}, 8'd0);
            chk("out_last_idle", {7'd0, out_last}, 8'd0);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (exp_vld && ordy) void'(q.pop_front());
            if (iv && exp_rdy) begin
                for (int k = 0; k < O; k++) begin
                    if (vec[k]) begin
                        b.idx = k[C-1:0]; b.empty = 1'b0; q.push_back(b);
                    end
                end
`ifdef ONEHOT_SER_EMPTY_FLAG_EN
                if (vec == 4'b0000) begin
                    b.idx = 2'd0; b.empty = 1'b1; q.push_back(b);
                end
`endif
            end
        end
        #1;
    endtask

    initial begin
        // Reset held 3 cycles with a bitmap offered.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'b1111, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        // Multi-bit bitmap, free-running consumer.
        cyc(1'b0, 1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        // Backpressure.
        cyc(1'b0, 1'b1, 4'b0110, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        // Back-to-back single-bit bitmaps.
        cyc(1'b0, 1'b1, 4'b1000, 1'b1);
        cyc(1'b0, 1'b1, 4'b0001, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        // Zero bitmap followed by a single-bit bitmap.
        cyc(1'b0, 1'b1, 4'b0000, 1'b1);
        cyc(1'b0, 1'b1, 4'b0100, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        // Reset mid-bitmap.
        cyc(1'b0, 1'b1, 4'b1111, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        cyc(1'b1, 1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
